// File: rtl/async_handshake_rx_if.sv
// Handshake bundle between a toggle-based CDC sender, the destination-side
// responder and its local valid/ready consumer.
interface async_handshake_rx_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   req_toggle;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_ready;
  logic                   ack_toggle;
  logic                   overrun;
  logic                   overrun_clr;
  logic [COUNT_WIDTH-1:0] xfer_count;

  // Environment side: sender plus consumer.
  modport master (
    output req_toggle, in_data, out_ready, overrun_clr,
    input  out_valid, out_data, ack_toggle, overrun, xfer_count
  );

  // Responder side.
  modport slave (
    input  req_toggle, in_data, out_ready, overrun_clr,
    output out_valid, out_data, ack_toggle, overrun, xfer_count
  );
endinterface

// File: rtl/async_handshake_rx.sv
// Destination end of a toggle req/ack crossing: synchronises req_toggle,
// captures the quasi-static word, hands it off via valid/ready, then toggles ack.
module async_handshake_rx #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  async_handshake_rx_if.slave  bus
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    IDLE   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   req_s;
  logic                   req_prev_reg, req_prev_next;
  logic                   req_edge;
  logic [WARM_W-1:0]      warm_cnt_reg, warm_cnt_next;
  logic                   out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0]  out_data_reg, out_data_next;
  logic                   ack_reg, ack_next;
  logic                   overrun_reg, overrun_next;
  logic [COUNT_WIDTH-1:0] count_reg, count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.req_toggle};
    end
  end

  assign req_s    = sync_reg[SYNC_STAGES-1];
  assign req_edge = req_s ^ req_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= WARMUP;
      req_prev_reg  <= 1'b0;
      warm_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      ack_reg       <= 1'b0;
      overrun_reg   <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      req_prev_reg  <= req_prev_next;
      warm_cnt_reg  <= warm_cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      ack_reg       <= ack_next;
      overrun_reg   <= overrun_next;
      count_reg     <= count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    req_prev_next  = req_prev_reg;
    warm_cnt_next  = warm_cnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    ack_next       = ack_reg;
    overrun_next   = overrun_reg;
    count_next     = count_reg;

    // Clear first so a violation in the same cycle overrides it.
    if (bus.overrun_clr) begin
      overrun_next = 1'b0;
    end

    case (state_reg)
      WARMUP: begin
        // Absorb whatever level the sender left on req_toggle.
        req_prev_next = req_s;
        if (warm_cnt_reg == WARM_LAST) begin
          state_next = IDLE;
        end else begin
          warm_cnt_next = warm_cnt_reg + WARM_W'(1);
        end
      end
      IDLE: begin
        req_prev_next = req_s;
        if (req_edge) begin
          out_data_next  = bus.in_data;
          out_valid_next = 1'b1;
          state_next     = HOLD;
        end
      end
      HOLD: begin
        if (out_valid_reg && bus.out_ready) begin
          // req_prev left alone so a coincident edge is taken next cycle in IDLE.
          out_valid_next = 1'b0;
          ack_next       = ~ack_reg;
          count_next     = count_reg + COUNT_WIDTH'(1);
          state_next     = IDLE;
        end else begin
          req_prev_next = req_s;
          if (req_edge) begin
            overrun_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = WARMUP;
      end
    endcase
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.ack_toggle = ack_reg;
  assign bus.overrun    = overrun_reg;
  assign bus.xfer_count = count_reg;

endmodule

// File: tb/tb_async_handshake_rx.sv
// Directed and sender-model bench for async_handshake_rx (SYNC_STAGES=2).
module tb_async_handshake_rx;

  logic clk;
  logic rst_n;
  int   vec;
  int   err;
  int   exp_count;
  logic exp_ack;

  async_handshake_rx_if #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) bus ();

  async_handshake_rx #(.DATA_WIDTH(32), .SYNC_STAGES(2), .COUNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic req_level);
    rst_n = 1'b0;
    bus.req_toggle  = req_level;
    bus.in_data     = 32'h0;
    bus.out_ready   = 1'b0;
    bus.overrun_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    exp_count = 0;
    exp_ack   = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    bus.in_data    = d;
    bus.req_toggle = ~bus.req_toggle;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_toggle  = 1'b1;
    bus.in_data     = 32'hFFFF_FFFF;
    bus.out_ready   = 1'b0;
    bus.overrun_clr = 1'b0;
    #3;
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    vec++; if (bus.out_data !== 32'h0) begin err++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
    vec++; if (bus.ack_toggle !== 1'b0) begin err++; $display("FAIL reset_ack: got %b want 0", bus.ack_toggle); end
    vec++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    vec++; if (bus.xfer_count !== 16'h0) begin err++; $display("FAIL reset_count: got %0d want 0", bus.xfer_count); end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vec++; if (bus.out_valid !== 1'b0 || bus.ack_toggle !== 1'b0) begin
        err++; $display("FAIL warmup_quiet: cycle %0d got valid=%b ack=%b want 0/0", i, bus.out_valid, bus.ack_toggle);
      end
    end
    $display("test_reset: req held high through release, no spurious word");
  endtask

  task automatic test_single();
    do_reset(1'b0);
    repeat (5) tick();
    bus.out_ready = 1'b1;
    send(32'hDEADBEEF);
    tick();
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL single_lat1: got %b want 0", bus.out_valid); end
    tick();
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL single_lat2: got %b want 0", bus.out_valid); end
    tick();
    vec++; if (bus.out_valid !== 1'b1) begin err++; $display("FAIL single_lat3: got %b want 1", bus.out_valid); end
    vec++; if (bus.out_data !== 32'hDEADBEEF) begin err++; $display("FAIL single_data: got %h want deadbeef", bus.out_data); end
    vec++; if (bus.ack_toggle !== 1'b0) begin err++; $display("FAIL single_ack_early: got %b want 0", bus.ack_toggle); end
    tick();
    exp_count++; exp_ack = ~exp_ack;
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL single_valid_drop: got %b want 0", bus.out_valid); end
    vec++; if (bus.ack_toggle !== exp_ack) begin err++; $display("FAIL single_ack: got %b want %b", bus.ack_toggle, exp_ack); end
    vec++; if (bus.xfer_count !== 16'(exp_count)) begin err++; $display("FAIL single_count: got %0d want %0d", bus.xfer_count, exp_count); end
    bus.out_ready = 1'b0;
    $display("test_single: word deadbeef delivered, count=%0d", bus.xfer_count);
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    send(32'h12345678);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h12345678 || bus.ack_toggle !== exp_ack) begin
        err++; $display("FAIL stall_hold: cycle %0d got valid=%b data=%h ack=%b want 1/12345678/%b",
                        i, bus.out_valid, bus.out_data, bus.ack_toggle, exp_ack);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_count++; exp_ack = ~exp_ack;
    vec++; if (bus.out_valid !== 1'b0 || bus.ack_toggle !== exp_ack) begin
      err++; $display("FAIL stall_accept: got valid=%b ack=%b want 0/%b", bus.out_valid, bus.ack_toggle, exp_ack);
    end
    repeat (4) tick();
    vec++; if (bus.ack_toggle !== exp_ack || bus.xfer_count !== 16'(exp_count)) begin
      err++; $display("FAIL stall_single_ack: got ack=%b count=%0d want %b/%0d", bus.ack_toggle, bus.xfer_count, exp_ack, exp_count);
    end
    $display("test_stall: 10-cycle stall then one ack, count=%0d", bus.xfer_count);
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b0;
    send(32'hA5A5A5A5);
    repeat (3) tick();
    vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5A5A5A5) begin
      err++; $display("FAIL ovr_first: got valid=%b data=%h want 1/a5a5a5a5", bus.out_valid, bus.out_data);
    end
    send(32'h5A5A5A5A);
    repeat (4) tick();
    vec++; if (bus.overrun !== 1'b1) begin err++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
    vec++; if (bus.out_data !== 32'hA5A5A5A5 || bus.out_valid !== 1'b1) begin
      err++; $display("FAIL ovr_intact: got valid=%b data=%h want 1/a5a5a5a5", bus.out_valid, bus.out_data);
    end
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    vec++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL ovr_clear: got %b want 0", bus.overrun); end
    // Third toggle timed so its edge cycle coincides with a clear pulse.
    send(32'h0BAD0BAD);
    tick();
    tick();
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    vec++; if (bus.overrun !== 1'b1) begin err++; $display("FAIL ovr_set_wins: got %b want 1", bus.overrun); end
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    vec++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL ovr_clear2: got %b want 0", bus.overrun); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_count++; exp_ack = ~exp_ack;
    vec++; if (bus.ack_toggle !== exp_ack || bus.xfer_count !== 16'(exp_count)) begin
      err++; $display("FAIL ovr_accept: got ack=%b count=%0d want %b/%0d", bus.ack_toggle, bus.xfer_count, exp_ack, exp_count);
    end
    repeat (5) tick();
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL ovr_no_ghost: got valid=%b want 0", bus.out_valid); end
    $display("test_overrun: lost words dropped, first word a5a5a5a5 kept");
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    send(32'h11110001);
    repeat (3) tick();
    vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11110001) begin
      err++; $display("FAIL b2b_first: got valid=%b data=%h want 1/11110001", bus.out_valid, bus.out_data);
    end
    send(32'h22220002);
    tick();
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_count++; exp_ack = ~exp_ack;
    vec++; if (bus.out_valid !== 1'b0 || bus.ack_toggle !== exp_ack) begin
      err++; $display("FAIL b2b_accept: got valid=%b ack=%b want 0/%b", bus.out_valid, bus.ack_toggle, exp_ack);
    end
    tick();
    vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h22220002 || bus.overrun !== 1'b0) begin
      err++; $display("FAIL b2b_second: got valid=%b data=%h ovr=%b want 1/22220002/0", bus.out_valid, bus.out_data, bus.overrun);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_count++; exp_ack = ~exp_ack;
    vec++; if (bus.ack_toggle !== exp_ack || bus.xfer_count !== 16'(exp_count)) begin
      err++; $display("FAIL b2b_end: got ack=%b count=%0d want %b/%0d", bus.ack_toggle, bus.xfer_count, exp_ack, exp_count);
    end
    $display("test_back_to_back: accept and new edge in same cycle, both words delivered");
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int          rcv;
    int          sent;
    rcv  = 0;
    sent = 0;
    fork
      begin : sender
        logic last_ack;
        int   wait_cyc;
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 4)) tick();
          last_ack = bus.ack_toggle;
          q.push_back($urandom);
          send(q[q.size()-1]);
          sent++;
          wait_cyc = 0;
          while (bus.ack_toggle === last_ack && wait_cyc < 200) begin
            tick();
            wait_cyc++;
          end
          if (bus.ack_toggle === last_ack) begin
            vec++; err++;
            $display("FAIL rand_ack_timeout: word %0d got no ack within %0d cycles", i, wait_cyc);
            break;
          end
        end
      end
      begin : consumer
        logic [31:0] exp_word;
        int          cyc;
        cyc = 0;
        while (rcv < 1000 && cyc < 30000) begin
          tick();
          cyc++;
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            vec++;
            if (q.size() == 0) begin
              err++; $display("FAIL rand_extra_word: got %h with nothing outstanding", bus.out_data);
            end else begin
              exp_word = q.pop_front();
              if (bus.out_data !== exp_word) begin
                err++; $display("FAIL rand_word: index %0d got %h want %h", rcv, bus.out_data, exp_word);
              end else begin
                $display("rand word %0d: %h", rcv, bus.out_data);
              end
            end
            rcv++;
          end
        end
      end
    join
    tick();
    bus.out_ready = 1'b0;
    exp_count = (exp_count + 1000) % 65536;
    vec++; if (rcv != 1000 || sent != 1000) begin err++; $display("FAIL rand_total: got sent=%0d rcv=%0d want 1000/1000", sent, rcv); end
    vec++; if (bus.xfer_count !== 16'(exp_count)) begin err++; $display("FAIL rand_count: got %0d want %0d", bus.xfer_count, exp_count); end
    vec++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL rand_overrun: got %b want 0", bus.overrun); end
    vec++; if (bus.ack_toggle !== exp_ack) begin err++; $display("FAIL rand_ack_parity: got %b want %b", bus.ack_toggle, exp_ack); end
    $display("test_random: %0d words received, count=%0d", rcv, bus.xfer_count);
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    send(32'hCAFEF00D);
    repeat (3) tick();
    vec++; if (bus.out_valid !== 1'b1) begin err++; $display("FAIL arst_hold: got valid=%b want 1", bus.out_valid); end
    rst_n = 1'b0;
    #2;
    vec++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.xfer_count !== 16'h0 || bus.ack_toggle !== 1'b0) begin
      err++; $display("FAIL arst_async: got valid=%b data=%h count=%0d ack=%b want 0/0/0/0",
                      bus.out_valid, bus.out_data, bus.xfer_count, bus.ack_toggle);
    end
    tick();
    tick();
    rst_n = 1'b1;
    exp_count = 0;
    exp_ack   = 1'b0;
    repeat (10) tick();
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL arst_no_spurious: got valid=%b want 0", bus.out_valid); end
    bus.out_ready = 1'b1;
    send(32'h0F0F0F0F);
    repeat (3) tick();
    vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0F0F0F0F) begin
      err++; $display("FAIL arst_resume_data: got valid=%b data=%h want 1/0f0f0f0f", bus.out_valid, bus.out_data);
    end
    tick();
    bus.out_ready = 1'b0;
    exp_count++; exp_ack = ~exp_ack;
    vec++; if (bus.ack_toggle !== exp_ack || bus.xfer_count !== 16'(exp_count)) begin
      err++; $display("FAIL arst_resume_ack: got ack=%b count=%0d want %b/%0d", bus.ack_toggle, bus.xfer_count, exp_ack, exp_count);
    end
    $display("test_async_reset: HOLD discarded asynchronously, resumed with count=%0d", bus.xfer_count);
  endtask

  initial begin
    vec = 0;
    err = 0;
    exp_count = 0;
    exp_ack = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/async_handshake_rx.md
Name: async_handshake_rx

Overview:
- Destination-side responder of a toggle-based request/acknowledge crossing.
- A foreign-domain sender drives a data word and flips `req_toggle`; this block synchronises the toggle and captures the word.
- It presents the word to a local consumer with a valid/ready handshake, then flips `ack_toggle` back to the sender once the word is consumed.
- Sits at the `clk` end of every multi-bit clock-domain crossing. Pairs with a sender that holds `in_data` stable from its toggle until it sees the ack.

Parameters:
- DATA_WIDTH, 32, width of transferred word.
- SYNC_STAGES, 2, synchroniser flops on `req_toggle` (legal ≥2).
- COUNT_WIDTH, 16, width of completed-transfer counter.

Ports:
- clk  in  1  destination clock; all flops on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_toggle  in  1  request toggle from sender domain (asynchronous to clk).
- in_data  in  DATA_WIDTH  sender data; quasi-static while a request is outstanding.
- out_valid  out  1  captured word available.
- out_data  out  DATA_WIDTH  captured word.
- out_ready  in  1  consumer accepts word.
- ack_toggle  out  1  acknowledge toggle to sender domain (registered, glitch-free).
- overrun  out  1  sticky protocol-violation flag.
- overrun_clr  in  1  synchronous clear of `overrun`.
- xfer_count  out  COUNT_WIDTH  number of completed transfers, wraps.

Behaviour:
- Reset (async assert, sync release via clk):
  - `out_valid`=0, `out_data`=0, `ack_toggle`=0, `overrun`=0, `xfer_count`=0.
  - Sync chain, `req_prev` and warm-up counter cleared; state=WARMUP.
- Sync chain: `req_toggle` passes through SYNC_STAGES flops → `req_s`. The `req_prev` flop holds the previous `req_s`. `edge = req_s ^ req_prev`.
- WARMUP:
  - Lasts SYNC_STAGES+1 cycles after reset release.
  - `req_prev` tracks `req_s`; edges are ignored. This prevents a spurious request when the sender is not reset at the same time.
  - Then → IDLE.
- IDLE: on `edge` → `out_data` <= `in_data`, `out_valid` <= 1, → HOLD.
- HOLD:
  - On `out_valid & out_ready` → `out_valid` <= 0, `ack_toggle` <= ~`ack_toggle`, `xfer_count` <= `xfer_count`+1 (mod 2^COUNT_WIDTH), → IDLE.
  - `out_data` holds until the next capture.
- Latency:
  - `req_toggle` transition, set up before a clk edge, raises `out_valid` exactly SYNC_STAGES+1 clk edges later.
  - Ack toggles on the edge after the accepting cycle. No combinational path from `out_ready` to `ack_toggle`.
- Back-to-back: accept in cycle N and a new edge in cycle N are both legal. The accept completes in N; the edge is processed in N+1 (`req_prev` is not updated on that edge in N). No word is lost.
- Overrun:
  - An `edge` while in HOLD, other than the case above, is a protocol violation.
  - `overrun` <= 1; the word is not captured; `req_prev` updates; the FSM stays in HOLD.
  - `overrun_clr` and a new violation in the same cycle: set wins.
- `out_valid` stays high with `out_ready` low indefinitely; `out_data` is stable while `out_valid`.
- Reset mid-transfer: all state is discarded. `ack_toggle` returns to 0, so the sender must be reset in the same reset domain event.
- `in_data` is sampled only in the edge cycle; its value elsewhere is don't-care.

Test Plan:
- Reset release with `req_toggle`=1 held → `out_valid` stays 0 for 20 cycles; `ack_toggle`=0.
- After warm-up, set `in_data`=0xDEADBEEF, toggle `req` 0→1 with `out_ready`=1 → `out_valid` high 3 cycles later (SYNC_STAGES=2) for 1 cycle with `out_data`=0xDEADBEEF. `ack_toggle`=1 next cycle; `xfer_count`=1.
- `out_ready`=0 for 10 cycles after capture → `out_valid` and `out_data` stable, no ack. Raise ready → single ack toggle.
- Sender model sends 1000 words with random ack-to-req delays and random ready → all words received in order, `xfer_count`=1000 (mod 2^16), `overrun`=0.
- Two `req` toggles while `out_valid` held with ready=0 → `overrun`=1, second word not captured, first word intact. `overrun_clr` pulse → 0.
- `rst_n` asserted while in HOLD → outputs reset asynchronously (`out_valid`=0 before next clk edge); post-warm-up operation normal.
